// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared CORDIC angle-format constants and sweeper state type
package cordic_pkg;

    localparam int ANGLE_W        = 17;
    localparam int COUNT_W        = 16;
    localparam int FULL_CIRCLE    = 102944;
    localparam int HALF_CIRCLE    = 51472;
    localparam int QUARTER_CIRCLE = 25736;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/cordic_angle_wrap_add.sv
// rtl/cordic_angle_wrap_add.sv - combinational (a + b) mod FULL_CIRCLE
module cordic_angle_wrap_add
    import cordic_pkg::*;
#(
    parameter int W       = ANGLE_W,
    parameter int MODULUS = FULL_CIRCLE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    localparam logic [W:0] MOD = (W+1)'(MODULUS);

    logic [W:0] sum;
    logic [W:0] diff;

    // A single conditional subtract suffices: operands are < 2^W < 2*MODULUS
    // for reduction (b = 0), and both < MODULUS for the increment.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = sum - MOD;
        y    = (sum >= MOD) ? diff[W-1:0] : sum[W-1:0];
    end

endmodule

// File: rtl/cordic_angle_sweeper.sv
// rtl/cordic_angle_sweeper.sv - programmed phase-angle sweep source for CORDIC_TOP
module cordic_angle_sweeper #(
    parameter int ANGLE_W     = cordic_pkg::ANGLE_W,
    parameter int COUNT_W     = cordic_pkg::COUNT_W,
    parameter int FULL_CIRCLE = cordic_pkg::FULL_CIRCLE
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Abort,
    input  logic [ANGLE_W-1:0] Start_angle,
    input  logic [ANGLE_W-1:0] Step_angle,
    input  logic [COUNT_W-1:0] Num_samples,
    input  logic               Angle_ready,
    output logic [ANGLE_W-1:0] Angle_out,
    output logic               Angle_valid,
    output logic               Busy,
    output logic               Done
);

    cordic_pkg::sweep_state_t state_q;
    logic [ANGLE_W-1:0]       angle_q;
    logic [ANGLE_W-1:0]       step_q;
    logic [COUNT_W-1:0]       remaining_q;

    logic [ANGLE_W-1:0] start_red;
    logic [ANGLE_W-1:0] step_red;
    logic [ANGLE_W-1:0] angle_next;

    cordic_angle_wrap_add #(.W(ANGLE_W), .MODULUS(FULL_CIRCLE)) u_start_red (
        .a (Start_angle),
        .b ('0),
        .y (start_red)
    );

    cordic_angle_wrap_add #(.W(ANGLE_W), .MODULUS(FULL_CIRCLE)) u_step_red (
        .a (Step_angle),
        .b ('0),
        .y (step_red)
    );

    cordic_angle_wrap_add #(.W(ANGLE_W), .MODULUS(FULL_CIRCLE)) u_inc (
        .a (angle_q),
        .b (step_q),
        .y (angle_next)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= cordic_pkg::IDLE;
            angle_q     <= '0;
            step_q      <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                cordic_pkg::IDLE: begin
                    if (Start && !Abort) begin
                        angle_q     <= start_red;
                        step_q      <= step_red;
                        remaining_q <= Num_samples;
                        state_q     <= (Num_samples == '0) ? cordic_pkg::DONE : cordic_pkg::RUN;
                    end
                end
                cordic_pkg::RUN: begin
                    if (Abort) begin
                        state_q <= cordic_pkg::IDLE;
                    end else if (Angle_ready) begin
                        angle_q     <= angle_next;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == COUNT_W'(1)) begin
                            state_q <= cordic_pkg::DONE;
                        end
                    end
                end
                cordic_pkg::DONE: begin
                    state_q <= cordic_pkg::IDLE;
                end
                default: begin
                    state_q <= cordic_pkg::IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from flops, so no input reaches them combinationally.
    assign Angle_out   = angle_q;
    assign Angle_valid = (state_q == cordic_pkg::RUN);
    assign Busy        = (state_q != cordic_pkg::IDLE);
    assign Done        = (state_q == cordic_pkg::DONE);

endmodule
